// File: rtl/layer_seq_pkg.sv
// Shared constants for the CNN layer sequencer: default sizing and the
// FSM state encodings, also used by the top-level datapath integration.
package layer_seq_pkg;

    localparam int STAGE_NUM_DEF     = 4;
    localparam int STG_W_DEF         = 2;
    localparam int TIMEOUT_WIDTH_DEF = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LAUNCH = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_NEXT   = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_LAUNCH = ST_LAUNCH,
        S_WAIT   = ST_WAIT,
        S_NEXT   = ST_NEXT,
        S_FINISH = ST_FINISH,
        S_ERROR  = ST_ERROR
    } seq_state_e;

endpackage

// File: rtl/layer_sequencer_stage_next_finder.sv
// Priority encoder picking the next enabled layer stage.
// With from_start set it returns the lowest enabled stage overall,
// otherwise the lowest enabled stage strictly above base.
module stage_next_finder
    import layer_seq_pkg::*;
#(
    parameter int STAGE_NUM = STAGE_NUM_DEF,
    parameter int STG_W     = STG_W_DEF
) (
    input  logic [STAGE_NUM-1:0] mask,
    input  logic [STG_W-1:0]     base,
    input  logic                 from_start,
    output logic [STG_W-1:0]     idx,
    output logic                 valid
);

    // Scan from the top down so the lowest qualifying index wins.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = STAGE_NUM - 1; i >= 0; i--) begin
            if (mask[i] && (from_start || (i > int'(base)))) begin
                idx   = STG_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Run controller for the MNIST CNN layer engines: launches enabled stages
// one at a time, steers the ping-pong feature buffers and watches for hangs.
// Optional cycle counter output enabled by defining LAYER_PERF_CNT_EN.
//
// state  | meaning
// IDLE   | waiting for a run request
// LAUNCH | one-cycle start pulse to the current stage, watchdog loaded
// WAIT   | waiting for the current stage's done, watchdog running
// NEXT   | flip buffers, pick the next enabled stage or finish
// FINISH | one-cycle run-complete pulse
// ERROR  | watchdog expired; held until the next run request
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int STAGE_NUM     = STAGE_NUM_DEF,
    parameter int STG_W         = STG_W_DEF,
    parameter int TIMEOUT_WIDTH = TIMEOUT_WIDTH_DEF
`ifdef LAYER_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH     = 32
`endif
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     axisif_in_start,
    output logic                     axisif_out_done,
    output logic                     out_busy,
    input  logic [STAGE_NUM-1:0]     in_stageMask,
    input  logic [TIMEOUT_WIDTH-1:0] in_timeoutLimit,
    output logic [STAGE_NUM-1:0]     out_stageStart,
    input  logic [STAGE_NUM-1:0]     in_stageDone,
    output logic [STG_W-1:0]         out_curStage,
    output logic                     out_bufSel,
    output logic                     out_error,
    output logic [STG_W-1:0]         out_errStage
`ifdef LAYER_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]     out_perfCycles
`endif
);

    seq_state_e               state_q, state_d;
    logic [STAGE_NUM-1:0]     mask_q, mask_d;
    logic [TIMEOUT_WIDTH-1:0] limit_q, limit_d;
    logic [TIMEOUT_WIDTH-1:0] timer_q, timer_d;
    logic [STG_W-1:0]         cur_q, cur_d;
    logic [STG_W-1:0]         err_stage_q, err_stage_d;
    logic                     buf_q, buf_d;

    logic                     idle_like;
    logic                     start_accept;
    logic [STAGE_NUM-1:0]     find_mask;
    logic [STG_W-1:0]         nxt_idx;
    logic                     nxt_valid;

    // A start from IDLE or ERROR uses the live mask; NEXT uses the latched one.
    assign idle_like    = (state_q == S_IDLE) || (state_q == S_ERROR);
    assign start_accept = idle_like && axisif_in_start;
    assign find_mask    = idle_like ? in_stageMask : mask_q;

    stage_next_finder #(
        .STAGE_NUM (STAGE_NUM),
        .STG_W     (STG_W)
    ) u_next_finder (
        .mask       (find_mask),
        .base       (cur_q),
        .from_start (idle_like),
        .idx        (nxt_idx),
        .valid      (nxt_valid)
    );

    // Next-state logic; the watchdog counts down from limit-1 and trips at zero.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        limit_d     = limit_q;
        timer_d     = timer_q;
        cur_d       = cur_q;
        err_stage_d = err_stage_q;
        buf_d       = buf_q;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (axisif_in_start) begin
                    mask_d  = in_stageMask;
                    limit_d = in_timeoutLimit;
                    buf_d   = 1'b0;
                    if (nxt_valid) begin
                        cur_d   = nxt_idx;
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                timer_d = limit_q - TIMEOUT_WIDTH'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (in_stageDone[cur_q]) begin
                    state_d = S_NEXT;
                end else if ((limit_q != '0) && (timer_q == '0)) begin
                    err_stage_d = cur_q;
                    state_d     = S_ERROR;
                end else begin
                    timer_d = timer_q - TIMEOUT_WIDTH'(1);
                end
            end
            S_NEXT: begin
                buf_d = ~buf_q;
                if (nxt_valid) begin
                    cur_d   = nxt_idx;
                    state_d = S_LAUNCH;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and run-context registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            limit_q     <= '0;
            timer_q     <= '0;
            cur_q       <= '0;
            err_stage_q <= '0;
            buf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            limit_q     <= limit_d;
            timer_q     <= timer_d;
            cur_q       <= cur_d;
            err_stage_q <= err_stage_d;
            buf_q       <= buf_d;
        end
    end

    // Moore outputs decoded from the registered state only.
    always_comb begin
        out_stageStart = '0;
        if (state_q == S_LAUNCH) begin
            out_stageStart[cur_q] = 1'b1;
        end
    end

    assign axisif_out_done = (state_q == S_FINISH);
    assign out_busy        = (state_q == S_LAUNCH) || (state_q == S_WAIT) ||
                             (state_q == S_NEXT)   || (state_q == S_FINISH);
    assign out_error       = (state_q == S_ERROR);
    assign out_errStage    = err_stage_q;
    assign out_curStage    = cur_q;
    assign out_bufSel      = buf_q;

`ifdef LAYER_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] perf_cnt_q, perf_cnt_d;
    logic [CNT_WIDTH-1:0] perf_out_q, perf_out_d;

    // Saturating run-length counter, snapshotted on entry to FINISH or ERROR.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        perf_out_d = perf_out_q;
        if (start_accept) begin
            perf_cnt_d = '0;
        end else if (out_busy && (perf_cnt_q != '1)) begin
            perf_cnt_d = perf_cnt_q + CNT_WIDTH'(1);
        end
        if ((state_d != state_q) && ((state_d == S_FINISH) || (state_d == S_ERROR))) begin
            perf_out_d = perf_cnt_d;
        end
    end

    // Perf registers; the snapshot holds between runs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
            perf_out_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            perf_out_q <= perf_out_d;
        end
    end

    assign out_perfCycles = perf_out_q;
`endif

endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer. Each run is planned up front:
// the planner derives the expected output timeline cycle by cycle from the
// sequencing rules, and writes the matching stimulus, including noise
// (foreign done bits, extra starts, mask/limit churn) that must be ignored.
module tb_layer_sequencer;

    localparam int MAXC = 8000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        done_o;
    logic        busy;
    logic [3:0]  mask;
    logic [15:0] limit;
    logic [3:0]  stg_start;
    logic [3:0]  stg_done;
    logic [1:0]  cur_stage;
    logic        buf_sel;
    logic        err;
    logic [1:0]  err_stage;

    always #5 clk = ~clk;

    layer_sequencer #(.STAGE_NUM(4), .STG_W(2), .TIMEOUT_WIDTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .axisif_in_start (start),
        .axisif_out_done (done_o),
        .out_busy        (busy),
        .in_stageMask    (mask),
        .in_timeoutLimit (limit),
        .out_stageStart  (stg_start),
        .in_stageDone    (stg_done),
        .out_curStage    (cur_stage),
        .out_bufSel      (buf_sel),
        .out_error       (err),
        .out_errStage    (err_stage)
    );

    // stimulus per interval c (applied just after edge c, sampled at edge c+1)
    logic        drv_rstn  [MAXC];
    logic        drv_start [MAXC];
    logic [3:0]  drv_mask  [MAXC];
    logic [15:0] drv_limit [MAXC];
    logic [3:0]  drv_done  [MAXC];

    // expected outputs per interval c (between edge c and edge c+1)
    logic [3:0]  exp_ss   [MAXC];
    logic        exp_done [MAXC];
    logic        exp_busy [MAXC];
    logic [1:0]  exp_cur  [MAXC];
    logic        exp_buf  [MAXC];
    logic        exp_err  [MAXC];
    logic [1:0]  exp_es   [MAXC];

    // persistent model values
    logic [1:0]  m_cur;
    logic        m_buf;
    logic        m_err;
    logic [1:0]  m_es;
    int          pos;
    int          total_cyc;
    int          cyc = -1;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic put(input int c, input logic [3:0] ss, input logic dn, input logic bs);
        exp_ss[c]   = ss;
        exp_done[c] = dn;
        exp_busy[c] = bs;
        exp_cur[c]  = m_cur;
        exp_buf[c]  = m_buf;
        exp_err[c]  = m_err;
        exp_es[c]   = m_es;
    endtask

    task automatic idle_to(input int c_end);
        for (int c = pos; c < c_end; c++) put(c, 4'h0, 1'b0, 1'b0);
        pos = c_end;
    endtask

    // One run with start sampled at edge c0; dl[i] = WAIT cycle in which stage i
    // answers (99 = never).
    task automatic plan_run(input int c0, input logic [3:0] msk, input logic [15:0] lim,
                            input int dl [4]);
        int c, L, nw;
        logic tmo;
        idle_to(c0);
        drv_start[c0-1] = 1'b1;
        drv_mask[c0-1]  = msk;
        drv_limit[c0-1] = lim;
        m_err = 1'b0;
        m_buf = 1'b0;
        c = c0;
        for (int i = 0; i < 4; i++) begin
            if (msk[i]) begin
                m_cur = 2'(i);
                L = c;
                put(L, 4'b0001 << i, 1'b0, 1'b1);
                tmo = (lim != 16'd0) && (dl[i] > int'(lim));
                nw  = tmo ? int'(lim) : dl[i];
                for (int k = 1; k <= nw; k++) begin
                    put(L + k, 4'h0, 1'b0, 1'b1);
                    drv_done[L + k][i] = 1'b0;
                    if ($urandom_range(0, 3) == 0) drv_start[L + k] = 1'b1;
                end
                if (tmo) begin
                    m_err = 1'b1;
                    m_es  = 2'(i);
                    pos   = L + nw + 1;
                    return;
                end
                drv_done[L + nw][i] = 1'b1;
                put(L + nw + 1, 4'h0, 1'b0, 1'b1);
                m_buf = ~m_buf;
                c = L + nw + 2;
            end
        end
        put(c, 4'h0, 1'b1, 1'b1);
        pos = c + 1;
    endtask

    // Run aborted by reset after k WAIT cycles of its first stage.
    task automatic plan_reset_run(input int c0, input logic [3:0] msk, input int k);
        int L, s;
        idle_to(c0);
        s = 0;
        for (int i = 3; i >= 0; i--) if (msk[i]) s = i;
        drv_start[c0-1] = 1'b1;
        drv_mask[c0-1]  = msk;
        drv_limit[c0-1] = 16'd0;
        m_err = 1'b0;
        m_buf = 1'b0;
        m_cur = 2'(s);
        L = c0;
        put(L, 4'b0001 << s, 1'b0, 1'b1);
        for (int j = 1; j <= k; j++) begin
            put(L + j, 4'h0, 1'b0, 1'b1);
            drv_done[L + j][s] = 1'b0;
        end
        drv_rstn[L + k]     = 1'b0;
        drv_rstn[L + k + 1] = 1'b0;
        m_cur = 2'd0;
        m_es  = 2'd0;
        put(L + k + 1, 4'h0, 1'b0, 1'b0);
        put(L + k + 2, 4'h0, 1'b0, 1'b0);
        drv_done[L + k + 3][s] = 1'b1;
        pos = L + k + 3;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // compare process: model every cycle plus a few hand-derived literal points
    always @(negedge clk) begin
        if (cyc >= 0 && cyc < total_cyc) begin
            chk("stage_start", 32'(stg_start), 32'(exp_ss[cyc]));
            chk("run_done",    32'(done_o),    32'(exp_done[cyc]));
            chk("busy",        32'(busy),      32'(exp_busy[cyc]));
            chk("cur_stage",   32'(cur_stage), 32'(exp_cur[cyc]));
            chk("buf_sel",     32'(buf_sel),   32'(exp_buf[cyc]));
            chk("error",       32'(err),       32'(exp_err[cyc]));
            chk("err_stage",   32'(err_stage), 32'(exp_es[cyc]));
            case (cyc)
                2:  begin chk("lit_rst_busy", 32'(busy), 0); chk("lit_rst_ss", 32'(stg_start), 0); end
                10: begin chk("lit_a_ss0", 32'(stg_start), 32'h1); chk("lit_a_buf0", 32'(buf_sel), 0); end
                15: begin chk("lit_a_ss1", 32'(stg_start), 32'h2); chk("lit_a_buf1", 32'(buf_sel), 1); end
                25: begin chk("lit_a_ss3", 32'(stg_start), 32'h8); chk("lit_a_buf3", 32'(buf_sel), 1); end
                30: chk("lit_a_done", 32'(done_o), 1);
                31: begin chk("lit_a_busy", 32'(busy), 0); chk("lit_a_done_end", 32'(done_o), 0); end
                45: begin chk("lit_b_noerr", 32'(err), 0); chk("lit_b_busy", 32'(busy), 1); end
                46: begin chk("lit_b_err", 32'(err), 1); chk("lit_b_es", 32'(err_stage), 0);
                          chk("lit_b_busy0", 32'(busy), 0); chk("lit_b_nodone", 32'(done_o), 0); end
                50: begin chk("lit_c_done", 32'(done_o), 1); chk("lit_c_clr", 32'(err), 0); end
                55: chk("lit_d_ss0", 32'(stg_start), 32'h1);
                61: chk("lit_d_noerr", 32'(err), 0);
                62: chk("lit_d_done", 32'(done_o), 1);
                70: begin chk("lit_e_ss1", 32'(stg_start), 32'h2); chk("lit_e_buf", 32'(buf_sel), 0); end
                75: begin chk("lit_e_ss3", 32'(stg_start), 32'h8); chk("lit_e_buf3", 32'(buf_sel), 1);
                          chk("lit_e_cur", 32'(cur_stage), 3); end
                80: chk("lit_e_done", 32'(done_o), 1);
                90: chk("lit_r_ss1", 32'(stg_start), 32'h2);
                95: begin chk("lit_r_busy", 32'(busy), 0); chk("lit_r_cur", 32'(cur_stage), 0); end
                default: ;
            endcase
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        int dl [4];
        int gap;
        logic [3:0]  rm;
        logic [15:0] rl;

        for (int c = 0; c < MAXC; c++) begin
            drv_rstn[c]  = 1'b1;
            drv_start[c] = 1'b0;
            drv_mask[c]  = 4'($urandom_range(0, 15));
            drv_limit[c] = 16'($urandom_range(0, 65535));
            drv_done[c]  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
        end
        drv_rstn[0] = 1'b0;
        drv_rstn[1] = 1'b0;
        m_cur = 2'd0; m_buf = 1'b0; m_err = 1'b0; m_es = 2'd0;
        pos = 0;

        dl = '{3, 3, 3, 3};
        plan_run(10, 4'b1111, 16'd0, dl);
        dl = '{99, 99, 99, 99};
        plan_run(40, 4'b0001, 16'd5, dl);
        plan_run(50, 4'b0000, 16'd5, dl);
        dl = '{5, 1, 1, 1};
        plan_run(55, 4'b0001, 16'd5, dl);
        dl = '{3, 3, 3, 3};
        plan_run(70, 4'b1010, 16'd0, dl);
        plan_reset_run(90, 4'b0110, 4);

        for (int r = 0; r < 80; r++) begin
            if (pos > MAXC - 200) break;
            rm = 4'($urandom_range(0, 15));
            rl = ($urandom_range(0, 2) == 0) ? 16'd0 : 16'($urandom_range(1, 8));
            for (int i = 0; i < 4; i++) begin
                dl[i] = $urandom_range(1, 10);
                if (rl != 16'd0 && $urandom_range(0, 3) == 0) dl[i] = 99;
            end
            gap = $urandom_range(1, 4);
            if (r % 10 == 9) plan_reset_run(pos + gap + 1, rm | 4'b0001, $urandom_range(1, 5));
            else plan_run(pos + gap + 1, rm, rl, dl);
        end
        idle_to(pos + 4);
        total_cyc = pos;

        rst_n    = 1'b0;
        start    = 1'b0;
        mask     = 4'h0;
        limit    = 16'h0;
        stg_done = 4'h0;
        for (int c = 0; c < total_cyc; c++) begin
            @(posedge clk);
            #1;
            rst_n    = drv_rstn[c];
            start    = drv_start[c];
            mask     = drv_mask[c];
            limit    = drv_limit[c];
            stg_done = drv_done[c];
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
